// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared constants, state encoding and helpers for intc_n
package intc_pkg;

    // Register word offsets, i.e. input_addr[4:2]
    localparam logic [2:0] OFS_PENDING = 3'd0;
    localparam logic [2:0] OFS_ENABLE  = 3'd1;
    localparam logic [2:0] OFS_MODE    = 3'd2;
    localparam logic [2:0] OFS_STATUS  = 3'd3;
    localparam logic [2:0] OFS_EOI     = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Ceiling log2 for elaboration-time width computation
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/intc_n_priority_encoder.sv
// rtl/intc_n_priority_encoder.sv - lowest-index-wins priority encoder
module priority_encoder_n
    import intc_pkg::*;
#(
    parameter int N_CH = 8,
    localparam int IDW = (clog2(N_CH) < 1) ? 1 : clog2(N_CH)
) (
    input  logic [N_CH-1:0] interrupts,
    output logic [IDW-1:0]  y,
    output logic            any
);

    // Scan from the top down so the lowest set index is the last assignment
    always_comb begin
        y   = '0;
        any = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (interrupts[i]) begin
                y   = IDW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intc_n.sv
// rtl/intc_n.sv - N-channel interrupt controller with register file and IACK/EOI handshake
module intc_n
    import intc_pkg::*;
#(
    parameter int N_CH = 8,
    parameter int AW   = 32,
    parameter int DW   = 32,
    localparam int IDW = (clog2(N_CH) < 1) ? 1 : clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    done,
    input  logic [N_CH*DW-1:0] isr_vec,
    input  logic [AW-1:0]      input_addr,
    input  logic [DW-1:0]      write_data,
    input  logic               write_enable,
    input  logic               IACK,
    output logic               IRQ,
    output logic [DW-1:0]      isr_addr,
    output logic [IDW-1:0]     irq_id,
    output logic               in_service,
    output logic [DW-1:0]      read_data
);

    state_t            state_q, state_d;
    logic [N_CH-1:0]   done_q, done_d;
    logic [N_CH-1:0]   pending_q, pending_d;   // edge-latched bits only
    logic [N_CH-1:0]   enable_q, enable_d;
    logic [N_CH-1:0]   mode_q, mode_d;         // 1 = edge, 0 = level
    logic              irq_q, irq_d;
    logic              in_service_q, in_service_d;
    logic [IDW-1:0]    irq_id_q, irq_id_d;
    logic [DW-1:0]     isr_addr_q, isr_addr_d;

    logic [2:0]        ofs;
    logic              wr_pending, wr_enable, wr_mode, wr_eoi;
    logic [N_CH-1:0]   pending_eff, eligible, iack_clr;
    logic [IDW-1:0]    win_id;
    logic              win_any;
    logic              unused_bits;

    assign ofs        = input_addr[4:2];
    assign wr_pending = write_enable && (ofs == OFS_PENDING);
    assign wr_enable  = write_enable && (ofs == OFS_ENABLE);
    assign wr_mode    = write_enable && (ofs == OFS_MODE);
    assign wr_eoi     = write_enable && (ofs == OFS_EOI);

    // Level channels bypass the latch and follow their request line directly
    assign pending_eff = (mode_q & pending_q) | (~mode_q & done);
    assign eligible    = pending_eff & enable_q;

    assign unused_bits = ^{input_addr[AW-1:5], input_addr[1:0], write_data};

    priority_encoder_n #(.N_CH(N_CH)) u_prio (
        .interrupts (eligible),
        .y          (win_id),
        .any        (win_any)
    );

    // Register file next state; a set on the same cycle as a clear wins,
    // and level-mode bits are held at zero so a switch to edge starts clean
    always_comb begin
        logic [N_CH-1:0] clr;
        logic [N_CH-1:0] set;
        done_d   = done;
        enable_d = wr_enable ? write_data[N_CH-1:0] : enable_q;
        mode_d   = wr_mode   ? write_data[N_CH-1:0] : mode_q;
        clr      = (wr_pending ? write_data[N_CH-1:0] : '0) | iack_clr;
        set      = done & ~done_q;
        pending_d = ((pending_q & ~clr) | set) & mode_q;
    end

    // Service FSM: latch a winner, wait for IACK, then wait for EOI
    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        in_service_d = in_service_q;
        irq_id_d     = irq_id_q;
        isr_addr_d   = isr_addr_q;
        iack_clr     = '0;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    irq_id_d   = win_id;
                    isr_addr_d = isr_vec[int'(win_id)*DW +: DW];
                    irq_d      = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (!eligible[irq_id_q]) begin
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end else if (IACK) begin
                    irq_d        = 1'b0;
                    in_service_d = 1'b1;
                    iack_clr     = N_CH'(1) << irq_id_q;
                    state_d      = SERVICE;
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                irq_d        = 1'b0;
                in_service_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            done_q       <= '0;
            pending_q    <= '0;
            enable_q     <= '1;
            mode_q       <= '1;
            irq_q        <= 1'b0;
            in_service_q <= 1'b0;
            irq_id_q     <= '0;
            isr_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            irq_q        <= irq_d;
            in_service_q <= in_service_d;
            irq_id_q     <= irq_id_d;
            isr_addr_q   <= isr_addr_d;
        end
    end

    // Combinational register read; unused bits and offsets read zero
    always_comb begin
        read_data = '0;
        case (ofs)
            OFS_PENDING: read_data[N_CH-1:0] = pending_eff;
            OFS_ENABLE:  read_data[N_CH-1:0] = enable_q;
            OFS_MODE:    read_data[N_CH-1:0] = mode_q;
            OFS_STATUS: begin
                read_data[0]       = irq_q;
                read_data[1]       = in_service_q;
                read_data[8 +: IDW] = irq_id_q;
            end
            default: read_data = '0;
        endcase
    end

    assign IRQ        = irq_q;
    assign isr_addr   = isr_addr_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_intc_n.sv
// tb/tb_intc_n.sv - scoreboard bench for intc_n
module tb_intc_n;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    done = '0;
    logic [255:0]  isr_vec;
    logic [31:0]   input_addr = '0;
    logic [31:0]   write_data = '0;
    logic          write_enable = 1'b0;
    logic          IACK = 1'b0;
    logic          IRQ;
    logic [31:0]   isr_addr;
    logic [2:0]    irq_id;
    logic          in_service;
    logic [31:0]   read_data;

    int checks = 0;
    int errors = 0;
    logic [2:0]  exp_id_q[$];
    logic [31:0] exp_addr_q[$];
    bit          sim_done = 1'b0;

    intc_n dut (
        .clk          (clk),
        .rst          (rst),
        .done         (done),
        .isr_vec      (isr_vec),
        .input_addr   (input_addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .IACK         (IACK),
        .IRQ          (IRQ),
        .isr_addr     (isr_addr),
        .irq_id       (irq_id),
        .in_service   (in_service),
        .read_data    (read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        input_addr   = addr;
        write_data   = data;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        input_addr = addr;
        #1;
        chk(name, read_data, exp);
    endtask

    task automatic pulse_done(input logic [7:0] mask);
        done = done | mask;
        tick();
        done = done & ~mask;
    endtask

    task automatic iack();
        IACK = 1'b1;
        tick();
        IACK = 1'b0;
    endtask

    task automatic expect_grant(input logic [2:0] id, input logic [31:0] addr);
        exp_id_q.push_back(id);
        exp_addr_q.push_back(addr);
    endtask

    task automatic wait_irq(input string name);
        int n;
        n = 0;
        while (IRQ !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(name, {31'd0, IRQ}, 32'd1);
    endtask

    // Monitor: every rising IRQ is a grant and must match the next queued expectation
    initial begin
        logic irq_prev;
        irq_prev = 1'b0;
        while (!sim_done) begin
            @(negedge clk);
            if (!rst && IRQ === 1'b1 && irq_prev !== 1'b1) begin
                if (exp_id_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_unexpected: got id %0d addr 0x%08h expected no grant", irq_id, isr_addr);
                end else begin
                    chk("grant_id", {29'd0, irq_id}, {29'd0, exp_id_q.pop_front()});
                    chk("grant_addr", isr_addr, exp_addr_q.pop_front());
                end
            end
            irq_prev = IRQ;
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            isr_vec[i*32 +: 32] = 32'h1000_0000 + 32'(i) * 32'h100;
        end
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        chk("rst_insvc", {31'd0, in_service}, 32'd0);
        chk("rst_isr_addr", isr_addr, 32'd0);
        rd("rst_pending", 32'h00, 32'h00);
        rd("rst_enable", 32'h04, 32'hFF);
        rd("rst_mode", 32'h08, 32'hFF);
        rd("rst_status", 32'h0C, 32'h0);
        rd("unused_ofs", 32'h14, 32'h0);

        // Single edge request on channel 3
        expect_grant(3'd3, 32'h1000_0300);
        pulse_done(8'h08);
        chk("t1_no_irq_yet", {31'd0, IRQ}, 32'd0);
        tick();
        chk("t1_irq_two_edges", {31'd0, IRQ}, 32'd1);
        rd("t1_status_req", 32'h0C, 32'h0000_0301);
        iack();
        chk("t1_irq_after_iack", {31'd0, IRQ}, 32'd0);
        chk("t1_insvc", {31'd0, in_service}, 32'd1);
        rd("t1_pending_clr", 32'h00, 32'h00);
        rd("t1_status_svc", 32'h0C, 32'h0000_0302);
        wr(32'h10, 32'h0);
        chk("t1_eoi", {31'd0, in_service}, 32'd0);

        // Simultaneous 5 and 2: lower index first
        expect_grant(3'd2, 32'h1000_0200);
        expect_grant(3'd5, 32'h1000_0500);
        pulse_done(8'h24);
        wait_irq("t2_first");
        rd("t2_pending_both", 32'h00, 32'h24);
        iack();
        wr(32'h10, 32'h0);
        wait_irq("t2_second");
        iack();
        rd("t2_pending_empty", 32'h00, 32'h00);
        wr(32'h10, 32'h0);

        // No preemption while in REQ
        expect_grant(3'd4, 32'h1000_0400);
        pulse_done(8'h10);
        wait_irq("t3_ch4");
        pulse_done(8'h01);
        tick();
        chk("t3_id_frozen", {29'd0, irq_id}, 32'd4);
        chk("t3_addr_frozen", isr_addr, 32'h1000_0400);
        rd("t3_pending", 32'h00, 32'h11);
        iack();
        rd("t3_pending_after_iack", 32'h00, 32'h01);
        expect_grant(3'd0, 32'h1000_0000);
        wr(32'h10, 32'h0);
        wait_irq("t3_ch0");
        iack();
        wr(32'h10, 32'h0);

        // Disabled channel records but does not request
        wr(32'h04, 32'hFE);
        pulse_done(8'h01);
        tick();
        tick();
        chk("t4_masked_irq", {31'd0, IRQ}, 32'd0);
        rd("t4_pending", 32'h00, 32'h01);
        expect_grant(3'd0, 32'h1000_0000);
        wr(32'h04, 32'hFF);
        wait_irq("t4_enabled");
        iack();
        wr(32'h10, 32'h0);

        // Level channel 1 re-requests while held, clears when dropped
        wr(32'h08, 32'hFD);
        rd("t5_mode", 32'h08, 32'hFD);
        expect_grant(3'd1, 32'h1000_0100);
        expect_grant(3'd1, 32'h1000_0100);
        done[1] = 1'b1;
        wait_irq("t5_first");
        rd("t5_pending_level", 32'h00, 32'h02);
        iack();
        rd("t5_pending_kept", 32'h00, 32'h02);
        wr(32'h10, 32'h0);
        wait_irq("t5_rerequest");
        iack();
        done[1] = 1'b0;
        #1;
        rd("t5_pending_dropped", 32'h00, 32'h00);
        wr(32'h10, 32'h0);
        tick();
        tick();
        tick();
        chk("t5_no_irq", {31'd0, IRQ}, 32'd0);

        // Reset during SERVICE
        expect_grant(3'd6, 32'h1000_0600);
        pulse_done(8'h40);
        wait_irq("t6_ch6");
        iack();
        wr(32'h04, 32'h0F);
        chk("t6_insvc", {31'd0, in_service}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_insvc", {31'd0, in_service}, 32'd0);
        chk("t6_async_irq", {31'd0, IRQ}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        rd("t6_enable", 32'h04, 32'hFF);
        rd("t6_mode", 32'h08, 32'hFF);
        rd("t6_pending", 32'h00, 32'h00);
        rd("t6_status", 32'h0C, 32'h0);
        chk("t6_isr_addr", isr_addr, 32'd0);
        wr(32'h10, 32'h0);
        tick();
        rd("t6_status_after_eoi", 32'h0C, 32'h0);

        tick();
        chk("queue_drained", 32'(exp_id_q.size()), 32'd0);
        sim_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
